// File: rtl/param_rr_arbiter_if.sv
// Requester-side handshake bundle for param_rr_arbiter.
// The lock vector exists only when PARAM_ARB_LOCK_EN is defined.
interface param_rr_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned IDW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   last;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] grant_id;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           busy;
`ifdef PARAM_ARB_LOCK_EN
  logic [N-1:0]   lock;

  modport master (output req, data_in, last, out_ready, lock,
                  input  gnt, grant_id, out_valid, out_data, busy);
  modport slave  (input  req, data_in, last, out_ready, lock,
                  output gnt, grant_id, out_valid, out_data, busy);
`else
  modport master (output req, data_in, last, out_ready,
                  input  gnt, grant_id, out_valid, out_data, busy);
  modport slave  (input  req, data_in, last, out_ready,
                  output gnt, grant_id, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit valid/ready datapath among N requesters.
// Define PARAM_ARB_LOCK_EN to add per-requester lock that suppresses the beat budget.
module param_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                clk,
  input  logic                rst,
  param_rr_arbiter_if.slave   bus
);
  localparam int unsigned IDW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned CW  = 8;

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_winner_q, last_winner_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic           own_req;
  logic           own_last;
  logic [W-1:0]   own_data;
  logic           accept;
  logic           budget_hit;
`ifdef PARAM_ARB_LOCK_EN
  logic           own_lock;
`endif

  // Rotating priority search starting just after the previous winner
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_winner_q) + k) % N;
      if (!pick_vld && bus.req[IDW'(idx)]) begin
        pick_vld = 1'b1;
        pick     = IDW'(idx);
      end
    end
  end

  // Owner's request-side signals selected by the registered grant index
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
`ifdef PARAM_ARB_LOCK_EN
    own_lock = 1'b0;
`endif
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_id_q == IDW'(i)) begin
        own_req  = bus.req[i];
        own_last = bus.last[i];
        own_data = bus.data_in[i*W +: W];
`ifdef PARAM_ARB_LOCK_EN
        own_lock = bus.lock[i];
`endif
      end
    end
  end

  assign bus.busy      = (state_q == S_OWN);
  assign bus.gnt       = gnt_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.out_valid = (state_q == S_OWN) & own_req;
  assign bus.out_data  = (state_q == S_OWN) ? own_data : '0;

  assign accept = bus.out_valid & bus.out_ready;

`ifdef PARAM_ARB_LOCK_EN
  assign budget_hit = !own_lock && (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_HOLD));
`else
  assign budget_hit = (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_HOLD));
`endif

  // Next-state: grant on any request, release on last / budget / request drop
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    grant_id_d    = grant_id_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d    = S_OWN;
          gnt_d      = N'(1) << pick;
          grant_id_d = pick;
          beat_cnt_d = '0;
        end
      end
      S_OWN: begin
        if (accept && (beat_cnt_q != 8'hFF)) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (!own_req || (accept && (own_last || budget_hit))) begin
          state_d       = S_IDLE;
          gnt_d         = '0;
          last_winner_d = grant_id_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      grant_id_q    <= '0;
      last_winner_q <= IDW'(N - 1);
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      grant_id_q    <= grant_id_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end
endmodule
